// File: rtl/jtframe_sdram_resp_pkg.sv
// Shared constants and types for the SDRAM responder: latency limits, default refresh
// timing and the refresh FSM states.
package jtframe_sdram_pkg;

    localparam int unsigned LAT_MIN         = 3;
    localparam int unsigned LAT_MAX         = 15;
    localparam int unsigned RFSH_PERIOD_DEF = 780;
    localparam int unsigned RFSH_CYC_DEF    = 4;
    localparam int unsigned AW_DEF          = 22;
    localparam int unsigned DW_DEF          = 32;

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StRun
    } rfsh_st_e;

endpackage

// File: rtl/jtframe_sdram_resp_if.sv
// Mux-side SDRAM request bus: req/ack handshake, write payload and read completion.
interface jtframe_sdram_resp_if
    import jtframe_sdram_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic              sdram_req;
    logic [AW-1:0]     sdram_addr;
    logic              sdram_rnw;
    logic [DW-1:0]     data_write;
    logic [DW/8-1:0]   sdram_wrmask;
    logic              sdram_ack;
    logic              data_rdy;
    logic [DW-1:0]     data_read;

    modport master (
        output sdram_req, sdram_addr, sdram_rnw, data_write, sdram_wrmask,
        input  sdram_ack, data_rdy, data_read
    );

    modport slave (
        input  sdram_req, sdram_addr, sdram_rnw, data_write, sdram_wrmask,
        output sdram_ack, data_rdy, data_read
    );
endinterface

// File: rtl/jtframe_sdram_dly.sv
// Valid/payload delay line of LATENCY stages; exposes the last two stages, where the
// memory strobe is issued and the access completes.
module jtframe_sdram_dly #(
    parameter int unsigned LATENCY = 5,
    parameter int unsigned W       = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         mid_valid,
    output logic [W-1:0] mid_data,
    output logic         last_valid,
    output logic [W-1:0] last_data
);
    logic [LATENCY-1:0] vld_q;
    logic [W-1:0]       dat_q [LATENCY];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) dat_q[i] <= '0;
        end else begin
            vld_q    <= {vld_q[LATENCY-2:0], in_valid};
            dat_q[0] <= in_data;
            for (int i = 1; i < int'(LATENCY); i++) dat_q[i] <= dat_q[i-1];
        end
    end

    assign mid_valid  = vld_q[LATENCY-2];
    assign mid_data   = dat_q[LATENCY-2];
    assign last_valid = vld_q[LATENCY-1];
    assign last_data  = dat_q[LATENCY-1];
endmodule

// File: rtl/jtframe_sdram_resp.sv
// SDRAM responder for jtframe_sdram_mux: fixed-latency pipelined accesses to a one-cycle
// synchronous memory port, refresh blocking and bus-idle statistics.
module jtframe_sdram_resp
    import jtframe_sdram_pkg::*;
#(
    parameter int unsigned AW          = AW_DEF,
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned LATENCY     = 5,
    parameter int unsigned MAXOUT      = 2,
    parameter int unsigned RFSH_PERIOD = RFSH_PERIOD_DEF,
    parameter int unsigned RFSH_CYC    = RFSH_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    jtframe_sdram_resp_if.slave  bus,
    input  logic                 refresh_en,
    input  logic                 hs,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_rd,
    output logic                 mem_we,
    output logic [DW/8-1:0]      mem_wmask,
    output logic [DW-1:0]        mem_din,
    input  logic [DW-1:0]        mem_dout,
    output logic                 busy,
    output logic [31:0]          idle_cnt,
    output logic [31:0]          total_cnt,
    output logic [15:0]          line_idle
);
    localparam int unsigned MW = DW / 8;
    localparam int unsigned PW = 1 + AW + DW + MW;

    logic          accept, ack_q, rfsh_run, expire, idle, hs_q, hs_fall;
    logic [3:0]    inflight_q;
    logic [15:0]   rfsh_cnt_q, run_cnt_q, run_cnt_d;
    logic          rearm_q, rearm_d;
    rfsh_st_e      st_q, st_d;
    logic [DW-1:0] rd_hold_q;
    logic [31:0]   idle_cnt_q, total_cnt_q;
    logic [15:0]   line_idle_q;

    logic          mid_v, last_v, mid_rnw, last_rnw, unused_last;
    logic [PW-1:0] in_p, mid_p, last_p;
    logic [AW-1:0] mid_addr;
    logic [DW-1:0] mid_dat;
    logic [MW-1:0] mid_msk;

    assign rfsh_run = (st_q == StRun);
    assign accept   = bus.sdram_req && !ack_q && (inflight_q < 4'(MAXOUT)) && !rfsh_run;
    assign in_p     = {bus.sdram_rnw, bus.sdram_addr, bus.data_write, bus.sdram_wrmask};

    jtframe_sdram_dly #(
        .LATENCY (LATENCY),
        .W       (PW)
    ) u_dly (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (accept),
        .in_data    (in_p),
        .mid_valid  (mid_v),
        .mid_data   (mid_p),
        .last_valid (last_v),
        .last_data  (last_p)
    );

    assign mid_rnw     = mid_p[PW-1];
    assign mid_addr    = mid_p[PW-2 -: AW];
    assign mid_dat     = mid_p[MW +: DW];
    assign mid_msk     = mid_p[MW-1:0];
    assign last_rnw    = last_p[PW-1];
    assign unused_last = ^last_p[PW-2:0];

    // Strobe fields are zeroed outside a strobe so the port never shows stale payload
    assign mem_rd    = mid_v & mid_rnw;
    assign mem_we    = mid_v & ~mid_rnw;
    assign mem_addr  = mid_v  ? mid_addr : '0;
    assign mem_din   = mem_we ? mid_dat  : '0;
    assign mem_wmask = mem_we ? mid_msk  : '0;

    assign bus.sdram_ack = ack_q;
    assign bus.data_rdy  = last_v;
    assign bus.data_read = (last_v && last_rnw) ? mem_dout : rd_hold_q;

    assign busy    = (inflight_q != 4'd0) || rfsh_run;
    assign expire  = refresh_en && (rfsh_cnt_q == 16'(RFSH_PERIOD - 1));
    assign idle    = !busy && !bus.sdram_req;
    assign hs_fall = hs_q && !hs;

    always_comb begin
        st_d      = st_q;
        run_cnt_d = run_cnt_q;
        rearm_d   = rearm_q;
        unique case (st_q)
            StIdle: if (expire) st_d = StPend;
            StPend: begin
                // Refresh yields to a request accepted in the same cycle
                if (inflight_q == 4'd0 && !accept) begin
                    st_d      = StRun;
                    run_cnt_d = 16'd0;
                end
            end
            StRun: begin
                if (expire) rearm_d = 1'b1;
                if (run_cnt_q == 16'(RFSH_CYC - 1)) begin
                    st_d    = (rearm_q || expire) ? StPend : StIdle;
                    rearm_d = 1'b0;
                end else begin
                    run_cnt_d = run_cnt_q + 16'd1;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_q       <= 1'b0;
            inflight_q  <= 4'd0;
            st_q        <= StIdle;
            rfsh_cnt_q  <= 16'd0;
            run_cnt_q   <= 16'd0;
            rearm_q     <= 1'b0;
            rd_hold_q   <= '0;
            hs_q        <= 1'b0;
            idle_cnt_q  <= 32'd0;
            total_cnt_q <= 32'd0;
            line_idle_q <= 16'd0;
        end else begin
            ack_q     <= accept;
            st_q      <= st_d;
            run_cnt_q <= run_cnt_d;
            rearm_q   <= rearm_d;
            hs_q      <= hs;
            case ({accept, last_v})
                2'b10:   inflight_q <= inflight_q + 4'd1;
                2'b01:   inflight_q <= inflight_q - 4'd1;
                default: inflight_q <= inflight_q;
            endcase
            if (refresh_en) rfsh_cnt_q <= expire ? 16'd0 : rfsh_cnt_q + 16'd1;
            if (last_v && last_rnw) rd_hold_q <= mem_dout;
            total_cnt_q <= total_cnt_q + 32'd1;
            if (idle) idle_cnt_q <= idle_cnt_q + 32'd1;
            if (hs_fall) line_idle_q <= 16'd0;
            else if (idle && line_idle_q != 16'hFFFF) line_idle_q <= line_idle_q + 16'd1;
        end
    end

    assign idle_cnt  = idle_cnt_q;
    assign total_cnt = total_cnt_q;
    assign line_idle = line_idle_q;
endmodule

// File: tb/tb_jtframe_sdram_resp.sv
// Directed bench for jtframe_sdram_resp with a behavioural one-cycle synchronous memory.
module tb_jtframe_sdram_resp;
    localparam int unsigned AW = 22;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rstn, refresh_en, hs;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_we, busy;
    logic [3:0]    mem_wmask;
    logic [DW-1:0] mem_din, mem_dout;
    logic [31:0]   idle_cnt, total_cnt;
    logic [15:0]   line_idle;

    int checks   = 0;
    int failures = 0;

    jtframe_sdram_resp_if #(.AW(AW), .DW(DW)) bus ();

    jtframe_sdram_resp #(
        .AW          (AW),
        .DW          (DW),
        .LATENCY     (5),
        .MAXOUT      (2),
        .RFSH_PERIOD (16),
        .RFSH_CYC    (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .refresh_en (refresh_en),
        .hs         (hs),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_wmask  (mem_wmask),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .busy       (busy),
        .idle_cnt   (idle_cnt),
        .total_cnt  (total_cnt),
        .line_idle  (line_idle)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_din[8*b +: 8];
        if (mem_rd) mem_dout <= mem[mem_addr[9:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic issue(input logic [21:0] a, input logic rnw, input logic [31:0] d,
                         input logic [3:0] m);
        bus.sdram_addr   = a;
        bus.sdram_rnw    = rnw;
        bus.data_write   = d;
        bus.sdram_wrmask = m;
        bus.sdram_req    = 1'b1;
    endtask

    // One isolated access: ack after 1, strobe after 4, data_rdy after 5 sample points
    task automatic access(input string tag, input logic [21:0] a, input logic rnw,
                          input logic [31:0] d, input logic [3:0] m, input logic [31:0] exp);
        issue(a, rnw, d, m);
        step();
        chk({tag, "_ack"}, 32'(bus.sdram_ack), 32'd1);
        bus.sdram_req = 1'b0;
        step();
        chk({tag, "_ack_low"}, 32'(bus.sdram_ack), 32'd0);
        step();
        step();
        chk({tag, "_strobe"}, 32'(rnw ? mem_rd : mem_we), 32'd1);
        chk({tag, "_maddr"}, 32'(mem_addr), 32'(a));
        if (!rnw) begin
            chk({tag, "_wmask"}, 32'(mem_wmask), 32'(m));
            chk({tag, "_din"}, mem_din, d);
        end
        step();
        chk({tag, "_rdy"}, 32'(bus.data_rdy), 32'd1);
        if (rnw) chk({tag, "_data"}, bus.data_read, exp);
        step();
        chk({tag, "_rdy_low"}, 32'(bus.data_rdy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int nack;
        int nrdy;
        rstn             = 1'b0;
        refresh_en       = 1'b0;
        hs               = 1'b0;
        ld_en            = 1'b0;
        ld_addr          = '0;
        ld_data          = '0;
        bus.sdram_req    = 1'b0;
        bus.sdram_addr   = '0;
        bus.sdram_rnw    = 1'b1;
        bus.data_write   = '0;
        bus.sdram_wrmask = '0;
        step();
        step();
        chk("rst_ack", 32'(bus.sdram_ack), 32'd0);
        chk("rst_rdy", 32'(bus.data_rdy), 32'd0);
        chk("rst_data", bus.data_read, 32'd0);
        chk("rst_strobes", 32'({mem_rd, mem_we}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_total", total_cnt, 32'd0);
        chk("rst_line", 32'(line_idle), 32'd0);

        // Idle statistics
        rstn = 1'b1;
        repeat (100) step();
        chk("st_idle", idle_cnt, 32'd100);
        chk("st_total", total_cnt, 32'd100);
        chk("st_line", 32'(line_idle), 32'd100);
        hs = 1'b1;
        step();
        hs = 1'b0;
        step();
        chk("st_line_clr", 32'(line_idle), 32'd0);
        chk("st_idle2", idle_cnt, 32'd102);

        poke(10'h100, 32'h1234ABCD);
        poke(10'h200, 32'h0000_0000);
        for (int k = 0; k < 4; k++) poke(10'(16 + k), 32'hC0DE_0010 + 32'(k));
        poke(10'h300, 32'h5A5A_3C3C);

        access("rd", 22'h100, 1'b1, 32'h0, 4'h0, 32'h1234ABCD);
        access("wr", 22'h200, 1'b0, 32'hFFFF_FFFF, 4'b0011, 32'h0);
        access("rdback", 22'h200, 1'b1, 32'h0, 4'h0, 32'h0000_FFFF);

        // Throughput: req held, address advances after each ack
        nack = 0;
        nrdy = 0;
        issue(22'h10, 1'b1, 32'h0, 4'h0);
        for (int n = 1; n <= 14; n++) begin
            step();
            chk($sformatf("tp_ack_%0d", n), 32'(bus.sdram_ack),
                32'(n == 1 || n == 3 || n == 7 || n == 9));
            chk($sformatf("tp_rdy_%0d", n), 32'(bus.data_rdy),
                32'(n == 5 || n == 7 || n == 11 || n == 13));
            if (bus.data_rdy) begin
                chk($sformatf("tp_data_%0d", nrdy), bus.data_read, 32'hC0DE_0010 + 32'(nrdy));
                nrdy++;
            end
            if (bus.sdram_ack) begin
                nack++;
                bus.sdram_addr = 22'h10 + 22'(nack);
                if (nack == 4) bus.sdram_req = 1'b0;
            end
        end

        // Refresh: expiry after 16 cycles, run occupies cycles 17..20
        rstn       = 1'b0;
        refresh_en = 1'b1;
        step();
        rstn = 1'b1;
        repeat (16) step();
        chk("rf_busy_pend", 32'(busy), 32'd0);
        step();
        chk("rf_busy_run", 32'(busy), 32'd1);
        issue(22'h300, 1'b1, 32'h0, 4'h0);
        chk("rf_strobe_17", 32'(mem_rd | mem_we), 32'd0);
        for (int n = 18; n <= 21; n++) begin
            step();
            chk($sformatf("rf_ack_%0d", n), 32'(bus.sdram_ack), 32'd0);
            chk($sformatf("rf_strobe_%0d", n), 32'(mem_rd | mem_we), 32'd0);
        end
        step();
        chk("rf_ack_22", 32'(bus.sdram_ack), 32'd1);
        bus.sdram_req = 1'b0;
        repeat (3) step();
        chk("rf_mem_rd", 32'(mem_rd), 32'd1);
        step();
        chk("rf_rdy", 32'(bus.data_rdy), 32'd1);
        chk("rf_data", bus.data_read, 32'h5A5A_3C3C);

        // Reset two cycles after an accept, before the strobe would issue
        refresh_en = 1'b0;
        issue(22'h100, 1'b1, 32'h0, 4'h0);
        step();
        chk("mr_ack", 32'(bus.sdram_ack), 32'd1);
        bus.sdram_req = 1'b0;
        step();
        step();
        rstn = 1'b0;
        #1;
        chk("mr_busy_in_rst", 32'(busy), 32'd0);
        rstn = 1'b1;
        #1;
        chk("mr_data", bus.data_read, 32'd0);
        chk("mr_total", total_cnt, 32'd0);
        chk("mr_idle", idle_cnt, 32'd0);
        chk("mr_ack_low", 32'(bus.sdram_ack), 32'd0);
        for (int n = 0; n < 4; n++) begin
            step();
            chk($sformatf("mr_rdy_%0d", n), 32'(bus.data_rdy), 32'd0);
            chk($sformatf("mr_strobe_%0d", n), 32'(mem_rd | mem_we), 32'd0);
            chk($sformatf("mr_busy_%0d", n), 32'(busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtframe_sdram_resp.md
# jtframe_sdram_resp

Parametrised SDRAM responder: it sits on the controller side of `jtframe_sdram_mux` and answers its `sdram_req`/`sdram_ack`/`data_rdy` protocol. It supports a configurable fixed latency, several requests in flight, masked writes and periodic refresh blocking. It also keeps bus-idle statistics, including per-line idle cycles cleared on horizontal sync. Storage is external through a one-cycle synchronous memory port, so the block serves both CPS video simulations and FPGA bring-up with BRAM.

## Interface
- `AW`, 22: word address width (16-bit words).
- `DW`, 32: data width; multiple of 16.
- `LATENCY`, 5: cycles from request sample to `data_rdy`; legal range 3..15.
- `MAXOUT`, 2: maximum requests in flight; legal range 1..LATENCY.
- `RFSH_PERIOD`, 780: cycles between refresh demands.
- `RFSH_CYC`, 4: cycles one refresh blocks acceptance.

Ports:
- `clk` in 1: single clock; one clock domain.
- `rstn` in 1: asynchronous, active-low reset.
- `sdram_req` in 1: request; held by the mux until it sees `sdram_ack`.
- `sdram_addr` in AW: word address.
- `sdram_rnw` in 1: 1 = read, 0 = write.
- `data_write` in DW: write data.
- `sdram_wrmask` in DW/8: byte enables; 1 = write the byte.
- `sdram_ack` out 1: one-cycle acceptance pulse.
- `data_rdy` out 1: one-cycle completion pulse, for both reads and writes.
- `data_read` out DW: read data; holds until the next read completion.
- `refresh_en` in 1: enables refresh demand counting.
- `hs` in 1: horizontal sync; its falling edge clears `line_idle`.
- `mem_addr` out AW, `mem_rd` out 1, `mem_we` out 1, `mem_wmask` out DW/8, `mem_din` out DW: memory port.
- `mem_dout` in DW: memory read data, valid one cycle after `mem_rd`.
- `busy` out 1: high when a request is in flight or a refresh is running.
- `idle_cnt` out 32, `total_cnt` out 32, `line_idle` out 16: statistics counters.

## Operation
- Accept condition: `sdram_req && !sdram_ack && inflight<MAXOUT && !rfsh_run`.
  - On accept, capture addr, rnw, data and mask into pipeline stage 0 and assert `sdram_ack` on the next cycle.
  - Back-to-back acceptance is therefore at most every 2 cycles.
- Delay line: LATENCY stages, each with a valid bit plus the captured request.
  - At stage LATENCY-2, issue `mem_rd` (read) or `mem_we` with mask and data (write).
  - At stage LATENCY-1, register `mem_dout` into `data_read` (reads only) and pulse `data_rdy`.
- `inflight` counter:
  - +1 on accept, −1 on completion; simultaneous accept and completion leaves it unchanged.
  - Never exceeds MAXOUT.
- Refresh:
  - While `refresh_en` is high, `rfsh_cnt` counts to RFSH_PERIOD-1, then wraps and sets `rfsh_pend`.
  - A second expiry while the pending flag is already set is dropped.
  - `rfsh_run` starts when `rfsh_pend && inflight==0` and no accept occurs that cycle. It lasts RFSH_CYC cycles and clears `rfsh_pend`.
  - Deasserting `refresh_en` freezes the counter but does not cancel a pending refresh.
- Statistics:
  - `total_cnt` increments every cycle and wraps.
  - `idle_cnt` increments when `!busy && !sdram_req` and wraps.
  - `line_idle` increments on the same condition and saturates at 16'hFFFF.
  - `hs` is registered; on a falling edge `line_idle` becomes 0, and the clear wins over a simultaneous increment.
- Reset: every output, counter, flag and pipeline valid bit goes to 0. Reset during activity discards all requests in flight; no `data_rdy` is issued for them.

## Timing
- Request sampled on edge t → `sdram_ack` high for edge t+1 only → `mem_rd`/`mem_we` at t+LATENCY-1 → `data_rdy` and `data_read` valid at t+LATENCY.
- Memory port strobes are single-cycle; `mem_addr`, `mem_din` and `mem_wmask` are valid only while a strobe is high.
- Refresh never overlaps a memory strobe. A request arriving during `rfsh_run` waits, and is accepted on the first cycle after the run ends.

## Structure
- Shared constants belong in package `jtframe_sdram_pkg`: latency limits and default refresh timings.
- Natural sub-module: `jtframe_sdram_dly`, a parametrised valid/payload delay line of LATENCY stages.
- Top level holds acceptance, the `inflight` counter, the refresh FSM (IDLE/PEND/RUN) and the statistics counters.

## Test plan
- Single read: memory word 0x1234ABCD at address 0x100, LATENCY=5. Request at t → ack at t+1, `mem_rd` at t+4, `data_rdy` with 0x1234ABCD at t+5.
- Masked write: write 0xFFFFFFFF to 0x200 with mask 4'b0011 over 0x00000000, then read back → 0x0000FFFF. `data_rdy` pulses for both accesses.
- Throughput, MAXOUT=2, LATENCY=5: mux holds req continuously for 4 reads → acks at t+1, t+3, t+7, t+9. The third accept waits for the first completion. Data returns in order.
- Refresh, RFSH_PERIOD=16, RFSH_CYC=4, `refresh_en` high: a request arriving on the first `rfsh_run` cycle is acked 4 cycles later. No memory strobe occurs during the run.
- Statistics: no traffic for 100 cycles → `idle_cnt`=`total_cnt`=100 and `line_idle`=100. Then an `hs` falling edge → `line_idle`=0 on the next cycle.
- Reset mid-flight: assert `rstn`=0 two cycles after an accept → no `data_rdy` is issued. All outputs are 0 and `inflight` is 0 after reset releases.
